// File: rtl/phase_clock_gen.sv
// Multi-phase clock-enable generator: rotates NUM_PHASES non-overlapping phase
// enables, each held for max(divide,1) cycles, optionally followed by GAP_CYCLES idle cycles.
module phase_clock_gen #(
    parameter int NUM_PHASES = 2,
    parameter int DIV_WIDTH  = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clkIn,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  divide,
    output logic [NUM_PHASES-1:0] phase,
    output logic [NUM_PHASES-1:0] phaseStart,
    output logic                  cycleDone,
    output logic                  running
);
    localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [NUM_PHASES-1:0] PHASE_ONE = NUM_PHASES'(1);

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t                  state_reg, state_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [DIV_WIDTH-1:0]    cnt_reg, cnt_next;
    logic [GAP_W-1:0]        gcnt_reg, gcnt_next;
    logic [NUM_PHASES-1:0]   phase_reg, phase_next;
    logic [NUM_PHASES-1:0]   start_reg, start_next;
    logic                    done_reg, done_next;
    logic                    running_reg, running_next;

    logic [DIV_WIDTH-1:0]    cnt_load;
    logic                    last_idx;
    logic [IDX_W-1:0]        idx_adv;
    logic                    do_adv;

    // divide==0 behaves like divide==1, so the reload value is divide-1 clamped at 0
    assign cnt_load = (divide == '0) ? '0 : divide - DIV_WIDTH'(1);
    assign last_idx = (idx_reg == IDX_W'(NUM_PHASES - 1));
    assign idx_adv  = last_idx ? '0 : idx_reg + IDX_W'(1);

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        cnt_next     = cnt_reg;
        gcnt_next    = gcnt_reg;
        phase_next   = phase_reg;
        start_next   = '0;
        done_next    = 1'b0;
        running_next = running_reg;
        do_adv       = 1'b0;

        case (state_reg)
            IDLE: begin
                phase_next   = '0;
                running_next = 1'b0;
                if (enable) begin
                    state_next   = ACTIVE;
                    idx_next     = '0;
                    phase_next   = PHASE_ONE;
                    start_next   = PHASE_ONE;
                    running_next = 1'b1;
                    cnt_next     = cnt_load;
                end
            end
            ACTIVE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - DIV_WIDTH'(1);
                end else if (GAP_CYCLES > 0) begin
                    state_next = GAP;
                    phase_next = '0;
                    gcnt_next  = GAP_W'(GAP_CYCLES - 1);
                end else begin
                    do_adv = 1'b1;
                end
            end
            GAP: begin
                if (gcnt_reg != '0) begin
                    gcnt_next = gcnt_reg - GAP_W'(1);
                end else begin
                    do_adv = 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                phase_next   = '0;
                running_next = 1'b0;
            end
        endcase

        // Enable is only consulted at the wrap, so a stop always finishes the rotation
        if (do_adv) begin
            idx_next  = idx_adv;
            done_next = last_idx;
            if (last_idx && !enable) begin
                state_next   = IDLE;
                phase_next   = '0;
                running_next = 1'b0;
            end else begin
                state_next = ACTIVE;
                phase_next = PHASE_ONE << idx_adv;
                start_next = PHASE_ONE << idx_adv;
                cnt_next   = cnt_load;
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            gcnt_reg    <= '0;
            phase_reg   <= '0;
            start_reg   <= '0;
            done_reg    <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            gcnt_reg    <= gcnt_next;
            phase_reg   <= phase_next;
            start_reg   <= start_next;
            done_reg    <= done_next;
            running_reg <= running_next;
        end
    end

    assign phase      = phase_reg;
    assign phaseStart = start_reg;
    assign cycleDone  = done_reg;
    assign running    = running_reg;
endmodule

// File: tb/tb_phase_clock_gen.sv
// Bench for phase_clock_gen: a 2-phase no-gap instance and a 4-phase one-gap instance,
// expected waveforms queued at drive time and compared one cycle later.
module tb_phase_clock_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst2, en2, cd2, run2;
    logic [7:0] div2;
    logic [1:0] ph2, ps2;
    logic       rst4, en4, cd4, run4;
    logic [7:0] div4;
    logic [3:0] ph4, ps4;

    phase_clock_gen #(.NUM_PHASES(2), .DIV_WIDTH(8), .GAP_CYCLES(0)) dut2 (
        .clkIn(clk), .reset(rst2), .enable(en2), .divide(div2),
        .phase(ph2), .phaseStart(ps2), .cycleDone(cd2), .running(run2));

    phase_clock_gen #(.NUM_PHASES(4), .DIV_WIDTH(8), .GAP_CYCLES(1)) dut4 (
        .clkIn(clk), .reset(rst4), .enable(en4), .divide(div4),
        .phase(ph4), .phaseStart(ps4), .cycleDone(cd4), .running(run4));

    typedef struct packed {
        logic [3:0] ph;
        logic [3:0] ps;
        logic       done;
        logic       run;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic [7:0] dv;
        exp_t       e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    bit   inv_on = 1'b0;
    exp_t q[$];
    vec_t tbl[15];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(logic [3:0] ph, logic [3:0] ps, logic done, logic run);
        exp_t r;
        r.ph = ph; r.ps = ps; r.done = done; r.run = run;
        return r;
    endfunction

    // Closed-form waveform of a free-running rotation, t = cycles since the first phase[0] cycle
    function automatic exp_t wave(int n, int gap, int dv, int t);
        int d, p, tt, k, off;
        exp_t r;
        d   = (dv == 0) ? 1 : dv;
        p   = d + gap;
        tt  = t % (n * p);
        k   = tt / p;
        off = tt % p;
        r.ph   = (off < d) ? (4'b0001 << k) : 4'b0000;
        r.ps   = (off == 0) ? (4'b0001 << k) : 4'b0000;
        r.done = (tt == 0) && (t > 0);
        r.run  = 1'b1;
        return r;
    endfunction

    function automatic exp_t obs(bit four);
        if (four) return mk(ph4, ps4, cd4, run4);
        return mk({2'b00, ph2}, {2'b00, ps2}, cd2, run2);
    endfunction

    task automatic check_pop(string name, bit four, int t);
        exp_t e, a;
        e = q.pop_front();
        a = obs(four);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0d: got ph=%b ps=%b done=%b run=%b, expected ph=%b ps=%b done=%b run=%b",
                     name, t, a.ph, a.ps, a.done, a.run, e.ph, e.ps, e.done, e.run);
        end else begin
            $display("ok   %s t=%0d ph=%b ps=%b done=%b run=%b", name, t, a.ph, a.ps, a.done, a.run);
        end
    endtask

    // Structural properties that must hold on every cycle for both instances
    always @(negedge clk) begin
        if (inv_on) begin
            checks++;
            if (!$onehot0(ph2) || ((ps2 & ~ph2) != 2'b00) || (!run2 && ph2 != 2'b00) ||
                !$onehot0(ph4) || ((ps4 & ~ph4) != 4'b0000) || (!run4 && ph4 != 4'b0000)) begin
                errors++;
                $display("FAIL invariant: got ph2=%b ps2=%b run2=%b ph4=%b ps4=%b run4=%b, required onehot0/subset/idle-zero",
                         ph2, ps2, run2, ph4, ps4, run4);
            end
        end
    end

    initial begin
        int dvs[2];
        exp_t e;

        // reset, idle, stop-at-wrap, divide=0 and reset-mid-phase on the 2-phase instance
        tbl[0]  = '{rst:1, en:1, dv:8'd1, e:mk(4'b0000, 4'b0000, 0, 0)};
        tbl[1]  = '{rst:1, en:1, dv:8'd1, e:mk(4'b0000, 4'b0000, 0, 0)};
        tbl[2]  = '{rst:0, en:0, dv:8'd1, e:mk(4'b0000, 4'b0000, 0, 0)};
        tbl[3]  = '{rst:0, en:1, dv:8'd2, e:mk(4'b0001, 4'b0001, 0, 1)};
        tbl[4]  = '{rst:0, en:1, dv:8'd2, e:mk(4'b0001, 4'b0000, 0, 1)};
        tbl[5]  = '{rst:0, en:0, dv:8'd2, e:mk(4'b0010, 4'b0010, 0, 1)};
        tbl[6]  = '{rst:0, en:0, dv:8'd2, e:mk(4'b0010, 4'b0000, 0, 1)};
        tbl[7]  = '{rst:0, en:0, dv:8'd2, e:mk(4'b0000, 4'b0000, 1, 0)};
        tbl[8]  = '{rst:0, en:0, dv:8'd2, e:mk(4'b0000, 4'b0000, 0, 0)};
        tbl[9]  = '{rst:0, en:1, dv:8'd0, e:mk(4'b0001, 4'b0001, 0, 1)};
        tbl[10] = '{rst:0, en:1, dv:8'd0, e:mk(4'b0010, 4'b0010, 0, 1)};
        tbl[11] = '{rst:0, en:1, dv:8'd0, e:mk(4'b0001, 4'b0001, 1, 1)};
        tbl[12] = '{rst:1, en:1, dv:8'd0, e:mk(4'b0000, 4'b0000, 0, 0)};
        tbl[13] = '{rst:1, en:1, dv:8'd0, e:mk(4'b0000, 4'b0000, 0, 0)};
        tbl[14] = '{rst:0, en:1, dv:8'd1, e:mk(4'b0001, 4'b0001, 0, 1)};

        rst2 = 1'b1; en2 = 1'b1; div2 = 8'd1;
        rst4 = 1'b1; en4 = 1'b0; div4 = 8'd3;

        for (int i = 0; i < 15; i++) begin
            rst2 = tbl[i].rst; en2 = tbl[i].en; div2 = tbl[i].dv;
            q.push_back(tbl[i].e);
            step();
            if (i == 0) inv_on = 1'b1;
            check_pop("vec", 1'b0, i);
        end

        // Free-running 2-phase rotation; divide=0 must match divide=1
        dvs[0] = 1; dvs[1] = 0;
        for (int j = 0; j < 2; j++) begin
            rst2 = 1'b1; step();
            rst2 = 1'b0; en2 = 1'b1; div2 = 8'(dvs[j]);
            for (int t = 0; t < ((j == 0) ? 100 : 20); t++) begin
                q.push_back(wave(2, 0, 1, t));
                step();
                check_pop((j == 0) ? "rot2_div1" : "rot2_div0", 1'b0, t);
            end
        end

        // divide changed mid-phase only affects the following phase
        rst2 = 1'b1; step();
        rst2 = 1'b0; en2 = 1'b1; div2 = 8'd2;
        for (int t = 0; t < 12; t++) begin
            e = mk((t < 2 || t >= 7) ? 4'b0001 : 4'b0010,
                   (t == 0 || t == 7) ? 4'b0001 : ((t == 2) ? 4'b0010 : 4'b0000),
                   t == 7, 1'b1);
            q.push_back(e);
            step();
            check_pop("div_change", 1'b0, t);
            if (t == 1) div2 = 8'd5;
        end
        rst2 = 1'b1;

        // 4-phase with one gap cycle, divide=3: period 16
        rst4 = 1'b0; en4 = 1'b1; div4 = 8'd3;
        for (int t = 0; t < 40; t++) begin
            q.push_back(wave(4, 1, 3, t));
            step();
            check_pop("rot4_gap", 1'b1, t);
        end

        // enable dropped during phase[1]: rotation and final gap complete, then idle
        rst4 = 1'b1; step();
        rst4 = 1'b0; en4 = 1'b1; div4 = 8'd2;
        for (int t = 0; t < 16; t++) begin
            e = (t < 12) ? wave(4, 1, 2, t) : mk(4'b0000, 4'b0000, t == 12, 1'b0);
            q.push_back(e);
            step();
            check_pop("stop4", 1'b1, t);
            if (t == 3) en4 = 1'b0;
        end
        en4 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            q.push_back(wave(4, 1, 2, t));
            step();
            check_pop("restart4", 1'b1, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
